if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage_if.sv | 37 +++
 rtl/if_stage.sv | 108 ++++++++++
 2 files changed

// File: rtl/if_stage_if.sv
// Fetch-stage bus: instruction SRAM port, redirect/stall
// controls from downstream, and the IF/ID register outputs.
interface if_stage_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] inst_in;
  logic [ADDR_WIDTH-1:0] addr_0;
  logic                  stall;
  logic                  redirect;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic [DATA_WIDTH-1:0] if_id_inst;
  logic [ADDR_WIDTH-1:0] if_id_pc;
  logic                  if_id_valid;

  modport master (
    input  inst_in,
    input  stall,
    input  redirect,
    input  redirect_pc,
    output addr_0,
    output if_id_inst,
    output if_id_pc,
    output if_id_valid
  );

  modport slave (
    output inst_in,
    output stall,
    output redirect,
    output redirect_pc,
    input  addr_0,
    input  if_id_inst,
    input  if_id_pc,
    input  if_id_valid
  );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch stage: word PC, async SRAM fetch, IF/ID register.
// Optional halt detection compiled in with macro IF_HALT_DETECT_EN.
module if_stage #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0,
  parameter logic [DATA_WIDTH-1:0] NOP_INST = '0
) (
  input  logic       clk,
  input  logic       reset_n,
  if_stage_if.master bus
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] inst;
    logic [ADDR_WIDTH-1:0] pc;
    logic                  valid;
  } if_id_t;

  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_nxt;
  logic [ADDR_WIDTH-1:0] w_pc_inc;
  if_id_t                r_if_id;
  if_id_t                w_if_id_nxt;

`ifdef IF_HALT_DETECT_EN
  logic r_halted;
  logic w_halted_nxt;
  logic w_halt_op;

  // Top opcode nibble all-ones marks a halt instruction
  assign w_halt_op = (bus.inst_in[15:12] == 4'hF);
`endif

  assign w_pc_inc = r_pc + 1'b1;

  // Next PC / IF/ID select; redirect outranks everything
  always_comb begin
    w_pc_nxt    = r_pc;
    w_if_id_nxt = r_if_id;
    priority case (1'b1)
      bus.redirect: begin
        w_pc_nxt          = bus.redirect_pc;
        w_if_id_nxt.inst  = NOP_INST;
        w_if_id_nxt.pc    = r_pc;
        w_if_id_nxt.valid = 1'b0;
      end
`ifdef IF_HALT_DETECT_EN
      r_halted: begin
        w_pc_nxt          = r_pc;
        w_if_id_nxt.inst  = NOP_INST;
        w_if_id_nxt.pc    = r_pc;
        w_if_id_nxt.valid = 1'b0;
      end
`endif
      bus.stall: begin
        w_pc_nxt    = r_pc;
        w_if_id_nxt = r_if_id;
      end
      default: begin
        w_pc_nxt          = w_pc_inc;
        w_if_id_nxt.inst  = bus.inst_in;
        w_if_id_nxt.pc    = r_pc;
        w_if_id_nxt.valid = 1'b1;
      end
    endcase
  end

`ifdef IF_HALT_DETECT_EN
  // Halt sets on a captured halt op, clears on redirect
  always_comb begin
    w_halted_nxt = r_halted;
    if (bus.redirect) begin
      w_halted_nxt = 1'b0;
    end else if (!r_halted && !bus.stall && w_halt_op) begin
      w_halted_nxt = 1'b1;
    end
  end

  // Halted flag register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_halted <= 1'b0;
    end else begin
      r_halted <= w_halted_nxt;
    end
  end
`endif

  // PC and IF/ID state registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc          <= RESET_PC;
      r_if_id.inst  <= NOP_INST;
      r_if_id.pc    <= RESET_PC;
      r_if_id.valid <= 1'b0;
    end else begin
      r_pc    <= w_pc_nxt;
      r_if_id <= w_if_id_nxt;
    end
  end

  assign bus.addr_0      = r_pc;
  assign bus.if_id_inst  = r_if_id.inst;
  assign bus.if_id_pc    = r_if_id.pc;
  assign bus.if_id_valid = r_if_id.valid;

endmodule
